// File: rtl/frame_wr_ctrl.sv
// rtl/frame_wr_ctrl.sv - frame-buffer write sequencer: vsync-framed pixel capture into linear BRAM addresses
module frame_wr_ctrl #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int DATA_W     = 12,
    parameter int ADDR_W     = $clog2(H_ACTIVE * V_ACTIVE),
    parameter int CONTINUOUS = 1
) (
    input  logic              wr_clk,
    input  logic              rst_n,
    input  logic              capture_en,
    input  logic              vsync,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              bram_en,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err,
    output logic [7:0]        frame_cnt
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_VS = 3'd1,
        ST_SYNC    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t              r_state;
    logic                r_vs_q;
    logic                r_hold;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic                r_bram_en;
    logic                r_done;
    logic                r_err;
    logic [7:0]          r_frame_cnt;

    logic w_vs_rise;
    logic w_vs_fall;

    assign w_vs_rise = vsync & ~r_vs_q;
    assign w_vs_fall = ~vsync & r_vs_q;

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_vs_q      <= 1'b0;
            r_hold      <= 1'b0;
            r_addr      <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_bram_en   <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_frame_cnt <= 8'd0;
        end else begin
            r_vs_q    <= vsync;
            r_wr_en   <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_bram_en <= (r_state != ST_IDLE);

            // Single-shot mode needs capture_en to drop before it will re-arm.
            if (!capture_en) begin
                r_hold <= 1'b0;
            end else if (r_state == ST_DONE && CONTINUOUS == 0) begin
                r_hold <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (capture_en && !r_hold) begin
                        r_state <= ST_WAIT_VS;
                    end
                end
                ST_WAIT_VS: begin
                    if (!capture_en) begin
                        r_state <= ST_IDLE;
                    end else if (w_vs_rise) begin
                        r_state <= ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (w_vs_fall) begin
                        r_addr  <= '0;
                        r_state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    // The final pixel wins over a coincident vsync rise.
                    if (pix_valid && r_addr == LAST_ADDR) begin
                        r_wr_en     <= 1'b1;
                        r_wr_addr   <= r_addr;
                        r_wr_data   <= pix_data;
                        r_addr      <= '0;
                        r_done      <= 1'b1;
                        r_frame_cnt <= r_frame_cnt + 8'd1;
                        r_state     <= ST_DONE;
                    end else if (w_vs_rise) begin
                        r_err   <= 1'b1;
                        r_addr  <= '0;
                        r_state <= ST_SYNC;
                    end else if (pix_valid) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_addr;
                        r_wr_data <= pix_data;
                        r_addr    <= r_addr + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (CONTINUOUS != 0 && capture_en) begin
                        r_state <= ST_WAIT_VS;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign bram_en    = r_bram_en;
    assign busy       = (r_state != ST_IDLE);
    assign frame_done = r_done;
    assign frame_err  = r_err;
    assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_frame_wr_ctrl.sv
// tb/tb_frame_wr_ctrl.sv - randomized bench for frame_wr_ctrl, continuous and single-shot instances against a model
module tb_frame_wr_ctrl;

    localparam int H = 16;
    localparam int V = 8;
    localparam int N = H * V;
    localparam int AW = $clog2(N);
    localparam int DW = 12;

    logic          wr_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          capture_en = 1'b0;
    logic          vsync = 1'b0;
    logic          pix_valid = 1'b0;
    logic [DW-1:0] pix_data = '0;

    logic          wr_en [2];
    logic [AW-1:0] wr_addr [2];
    logic [DW-1:0] wr_data [2];
    logic          bram_en [2];
    logic          busy [2];
    logic          frame_done [2];
    logic          frame_err [2];
    logic [7:0]    frame_cnt [2];

    int errors = 0;
    int checks = 0;

    always #5 wr_clk = ~wr_clk;

    frame_wr_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .DATA_W(DW), .ADDR_W(AW), .CONTINUOUS(1)) u_cont (
        .wr_clk(wr_clk), .rst_n(rst_n), .capture_en(capture_en), .vsync(vsync),
        .pix_valid(pix_valid), .pix_data(pix_data),
        .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]), .bram_en(bram_en[0]),
        .busy(busy[0]), .frame_done(frame_done[0]), .frame_err(frame_err[0]), .frame_cnt(frame_cnt[0])
    );

    frame_wr_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .DATA_W(DW), .ADDR_W(AW), .CONTINUOUS(0)) u_shot (
        .wr_clk(wr_clk), .rst_n(rst_n), .capture_en(capture_en), .vsync(vsync),
        .pix_valid(pix_valid), .pix_data(pix_data),
        .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]), .bram_en(bram_en[1]),
        .busy(busy[1]), .frame_done(frame_done[1]), .frame_err(frame_err[1]), .frame_cnt(frame_cnt[1])
    );

    // Model: phase 0 idle, 1 armed waiting for vsync rise, 2 waiting for vsync fall,
    // 3 counting pixels into the frame, 4 frame just finished.
    int  m_phase [2] = '{0, 0};
    int  m_pix   [2] = '{0, 0};
    bit  m_hold  [2] = '{0, 0};
    int  m_frames[2] = '{0, 0};
    bit  m_vs_prev = 0;
    bit  e_we    [2] = '{0, 0};
    int  e_addr  [2] = '{0, 0};
    int  e_data  [2] = '{0, 0};
    bit  e_bram  [2] = '{0, 0};
    bit  e_done  [2] = '{0, 0};
    bit  e_err   [2] = '{0, 0};

    task automatic model_step(input int k, input bit rise, input bit fall);
        bit cont;
        cont = (k == 0);
        e_we[k]   = 0;
        e_done[k] = 0;
        e_err[k]  = 0;
        e_bram[k] = (m_phase[k] != 0);
        if (!capture_en) m_hold[k] = 0;
        else if (m_phase[k] == 4 && !cont) m_hold[k] = 1;
        if (m_phase[k] == 0) begin
            if (capture_en && !m_hold[k]) m_phase[k] = 1;
        end else if (m_phase[k] == 1) begin
            if (!capture_en) m_phase[k] = 0;
            else if (rise) m_phase[k] = 2;
        end else if (m_phase[k] == 2) begin
            if (fall) begin
                m_phase[k] = 3;
                m_pix[k] = 0;
            end
        end else if (m_phase[k] == 3) begin
            if (pix_valid) begin
                if (m_pix[k] == N - 1 || !rise) begin
                    e_we[k] = 1;
                    e_addr[k] = m_pix[k];
                    e_data[k] = int'(pix_data);
                    m_pix[k]++;
                end
            end
            if (m_pix[k] == N) begin
                m_pix[k] = 0;
                m_phase[k] = 4;
                e_done[k] = 1;
                m_frames[k] = (m_frames[k] + 1) % 256;
            end else if (rise) begin
                e_err[k] = 1;
                m_pix[k] = 0;
                m_phase[k] = 2;
            end
        end else begin
            m_phase[k] = (cont && capture_en) ? 1 : 0;
        end
    endtask

    always @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vs_prev = 0;
            for (int k = 0; k < 2; k++) begin
                m_phase[k] = 0; m_pix[k] = 0; m_hold[k] = 0; m_frames[k] = 0;
                e_we[k] = 0; e_addr[k] = 0; e_data[k] = 0;
                e_bram[k] = 0; e_done[k] = 0; e_err[k] = 0;
            end
        end else begin
            bit rise, fall;
            rise = vsync && !m_vs_prev;
            fall = !vsync && m_vs_prev;
            m_vs_prev = vsync;
            for (int k = 0; k < 2; k++) model_step(k, rise, fall);
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    int wcount [2] = '{0, 0};

    always @(negedge wr_clk) begin
        for (int k = 0; k < 2; k++) begin
            check($sformatf("u%0d.ctl{we,bram,busy,done,err,cnt}", k),
                  {wr_en[k], bram_en[k], busy[k], frame_done[k], frame_err[k], frame_cnt[k]},
                  {e_we[k], e_bram[k], (m_phase[k] != 0), e_done[k], e_err[k], m_frames[k][7:0]});
            if (e_we[k]) begin
                check($sformatf("u%0d.wr_addr", k), int'(wr_addr[k]), e_addr[k]);
                check($sformatf("u%0d.wr_data", k), int'(wr_data[k]), e_data[k]);
            end
            if (wr_en[k] === 1'b1) wcount[k]++;
        end
    end

    task automatic tick();
        @(negedge wr_clk);
    endtask

    task automatic idle(input int n);
        pix_valid = 0;
        repeat (n) tick();
    endtask

    task automatic vs_pulse(input int len);
        vsync = 1;
        repeat (len) begin
            pix_valid = $urandom_range(1, 0);
            pix_data = DW'($urandom);
            tick();
        end
        vsync = 0;
        pix_valid = 0;
        tick();
    endtask

    task automatic feed(input int n);
        int sent = 0;
        while (sent < n) begin
            pix_valid = ($urandom_range(3, 0) != 0);
            pix_data = DW'($urandom);
            if (pix_valid) sent++;
            tick();
        end
        pix_valid = 0;
    endtask

    task automatic async_reset();
        @(negedge wr_clk);
        #2 rst_n = 0;
        #1;
        check("reset.wr_en", int'(wr_en[0]), 0);
        check("reset.bram_en", int'(bram_en[0]), 0);
        check("reset.busy", int'(busy[0]), 0);
        check("reset.frame_cnt", int'(frame_cnt[0]), 0);
    endtask

    int w0, w1;

    initial begin
        // Reset held with pixels toggling.
        for (int i = 0; i < 6; i++) begin
            pix_valid = i[0];
            pix_data = DW'(i);
            tick();
        end
        check("rst.wr_en", int'(wr_en[0]), 0);
        check("rst.bram_en", int'(bram_en[0]), 0);
        check("rst.busy", int'(busy[0]), 0);
        check("rst.frame_done", int'(frame_done[0]), 0);
        #2 rst_n = 1;
        tick();

        // Full frame into both instances.
        capture_en = 1;
        idle(2);
        w0 = wcount[0];
        w1 = wcount[1];
        vs_pulse(3);
        feed(N);
        idle(3);
        check("frame1.writes", wcount[0] - w0, N);
        check("frame1.cnt_cont", int'(frame_cnt[0]), 1);
        check("frame1.cnt_shot", int'(frame_cnt[1]), 1);
        check("frame1.shot_busy", int'(busy[1]), 0);

        // Extra pixels after a full frame are dropped.
        w0 = wcount[0];
        pix_valid = 1;
        repeat (10) tick();
        pix_valid = 0;
        check("extra.no_writes", wcount[0] - w0, 0);

        // Aborted frame then a complete one; single-shot stays put.
        vs_pulse(2);
        feed(40);
        vs_pulse(2);
        w0 = wcount[0];
        w1 = wcount[1];
        feed(N);
        idle(3);
        check("abort.refill_writes", wcount[0] - w0, N);
        check("abort.cnt_cont", int'(frame_cnt[0]), 2);
        check("shot.no_writes", wcount[1] - w1, 0);
        check("shot.cnt", int'(frame_cnt[1]), 1);

        // vsync rise coincident with the final pixel.
        vs_pulse(2);
        feed(N - 1);
        pix_valid = 1;
        vsync = 1;
        pix_data = DW'($urandom);
        tick();
        pix_valid = 0;
        idle(2);
        vsync = 0;
        idle(2);
        check("coincide.cnt", int'(frame_cnt[0]), 3);

        // capture_en dropped mid-frame: frame still completes, then idle.
        vs_pulse(2);
        feed(50);
        capture_en = 0;
        feed(N - 50);
        idle(3);
        check("stop.cnt", int'(frame_cnt[0]), 4);
        check("stop.busy", int'(busy[0]), 0);

        // Re-arm (also releases the single-shot instance), then reset mid-frame.
        capture_en = 1;
        idle(2);
        vs_pulse(2);
        feed(50);
        async_reset();
        tick();
        #2 rst_n = 1;
        idle(2);
        vs_pulse(2);
        feed(N);
        idle(3);
        check("post_reset.cnt", int'(frame_cnt[0]), 1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99, 0) < 2) vsync = ~vsync;
            if ($urandom_range(999, 0) < 3) capture_en = ~capture_en;
            pix_valid = ($urandom_range(3, 0) != 0);
            pix_data = DW'($urandom);
            tick();
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
